mem_burst_reader: RTL and testbench

- Reads a contiguous burst of words from a synchronous single-port memory (reg-array style, 1-cycle read latency) and streams them out over a valid/ready interface.
- It is the read-side counterpart to the memory writers in the design.
- It accepts a start address and a length, issues addresses, absorbs read latency in an internal 4-entry FIFO, and signals completion.

---
 rtl/mem_burst_reader.sv | 137 +++++++++++++
 tb/tb_mem_burst_reader.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_burst_reader.sv
// Streams a contiguous burst from a 1-cycle-latency memory out over valid/ready.
// Reads are credit-limited so the 4-entry return FIFO can never overflow.
module mem_burst_reader #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter int LEN_W  = 9
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [LEN_W-1:0]  start_len,
    output logic              busy,
    output logic              done,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last
);

    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(2 ** ADDR_W);

    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

    state_t            state;
    logic [ADDR_W-1:0] addr_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  issued_q;
    logic [LEN_W-1:0]  deliv_q;

    logic              rd_vld_p1;
    logic [DATA_W-1:0] fifo_mem [4];
    logic [1:0]        wr_ptr;
    logic [1:0]        rd_ptr;
    logic [2:0]        fifo_cnt;

    logic              credit_ok;
    logic              issue;
    logic              push;
    logic              pop;

    function automatic logic [LEN_W-1:0] sat_len(input logic [LEN_W-1:0] l);
        return (l > MAX_LEN) ? MAX_LEN : l;
    endfunction

    // Words already in the FIFO plus the one read still returning bound new issues.
    assign credit_ok = ({1'b0, fifo_cnt} + {3'b000, rd_vld_p1}) < 4'd4;
    assign issue     = (state == READ) && credit_ok && (issued_q < len_q);
    assign push      = rd_vld_p1;
    assign pop       = out_valid && out_ready;

    assign mem_rd_en = issue;
    assign mem_addr  = addr_q;
    assign busy      = (state == READ) || (state == DRAIN);
    assign done      = (state == DONE);
    assign out_valid = (fifo_cnt != 3'd0);
    assign out_data  = out_valid ? fifo_mem[rd_ptr] : '0;
    assign out_last  = out_valid && (deliv_q == len_q - LEN_W'(1));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            addr_q   <= '0;
            len_q    <= '0;
            issued_q <= '0;
            deliv_q  <= '0;
        end else begin
            if (pop) begin
                deliv_q <= deliv_q + LEN_W'(1);
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        if (start_len == '0) begin
                            state <= DONE;
                        end else begin
                            addr_q   <= start_addr;
                            len_q    <= sat_len(start_len);
                            issued_q <= '0;
                            deliv_q  <= '0;
                            state    <= READ;
                        end
                    end
                end
                READ: begin
                    if (issue) begin
                        addr_q   <= addr_q + ADDR_W'(1);
                        issued_q <= issued_q + LEN_W'(1);
                        if (issued_q + LEN_W'(1) == len_q) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (pop && out_last) begin
                        state <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Read-return stage: strobe delayed one cycle to line up with mem_rd_data.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_vld_p1 <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            fifo_cnt  <= '0;
        end else begin
            rd_vld_p1 <= issue;
            if (push) begin
                wr_ptr <= wr_ptr + 2'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 2'd1;
            end
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 3'd1;
                2'b01:   fifo_cnt <= fifo_cnt - 3'd1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            fifo_mem[wr_ptr] <= mem_rd_data;
        end
    end

endmodule

// File: tb/tb_mem_burst_reader.sv
// Randomised bench for mem_burst_reader: a memory model, an output monitor and
// per-scenario tasks comparing against words computed straight from the memory image.
module tb_mem_burst_reader;

    logic       clock = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] start_addr;
    logic [8:0] start_len;
    logic       busy;
    logic       done;
    logic       mem_rd_en;
    logic [7:0] mem_addr;
    logic [7:0] mem_rd_data = 8'h00;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_last;

    logic [7:0] mem [256];
    logic [7:0] rd_q [$];
    logic [7:0] dat_q [$];
    logic       last_q [$];
    int         hs_cyc_q [$];
    int         cyc = 0;
    int         busy_cnt = 0;
    int         valid_cnt = 0;
    int         n_pass = 0;
    int         n_total = 0;

    mem_burst_reader #(.DATA_W(8), .ADDR_W(8), .LEN_W(9)) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .start_addr  (start_addr),
        .start_len   (start_len),
        .busy        (busy),
        .done        (done),
        .mem_rd_en   (mem_rd_en),
        .mem_addr    (mem_addr),
        .mem_rd_data (mem_rd_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_last    (out_last)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (mem_rd_en) mem_rd_data <= mem[mem_addr];
    end

    always @(negedge clock) begin
        if (mem_rd_en) rd_q.push_back(mem_addr);
        if (out_valid && out_ready) begin
            dat_q.push_back(out_data);
            last_q.push_back(out_last);
            hs_cyc_q.push_back(cyc);
        end
        if (busy) busy_cnt <= busy_cnt + 1;
        if (out_valid) valid_cnt <= valid_cnt + 1;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Starts a burst from IDLE and waits for done; leaves the bench in the done cycle.
    task automatic launch(input logic [7:0] a, input logic [8:0] l, input int pct,
                          input int max_cyc, output bit to);
        tick();
        start = 1'b1; start_addr = a; start_len = l;
        out_ready = (int'($urandom_range(99, 0)) < pct);
        tick();
        start = 1'b0;
        to = 1'b1;
        for (int i = 0; i < max_cyc; i++) begin
            if (done === 1'b1) begin
                to = 1'b0;
                break;
            end
            out_ready = (int'($urandom_range(99, 0)) < pct);
            tick();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; start_addr = 8'h00; start_len = 9'd0; out_ready = 1'b0;
        #2 reset = 1'b0;
        #1;
        n_total++;
        if ({busy, done, mem_rd_en, out_valid, out_last} !== 5'b0)
            $display("FAIL reset_ctrl got %b want 00000", {busy, done, mem_rd_en, out_valid, out_last});
        else n_pass++;
        n_total++;
        if (out_data !== 8'h00) $display("FAIL reset_data got %h want 00", out_data); else n_pass++;
        n_total++;
        if (mem_addr !== 8'h00) $display("FAIL reset_addr got %h want 00", mem_addr); else n_pass++;
        start = 1'b1; start_len = 9'd3;
        tick();
        tick();
        n_total++;
        if ({busy, mem_rd_en} !== 2'b00) $display("FAIL reset_hold got %b want 00", {busy, mem_rd_en});
        else n_pass++;
        start = 1'b0;
        reset = 1'b1;
        tick();
        n_total++;
        if ({busy, done, mem_rd_en, out_valid} !== 4'b0)
            $display("FAIL reset_idle got %b want 0000", {busy, done, mem_rd_en, out_valid});
        else n_pass++;
    endtask

    task automatic test_basic();
        logic [7:0] exp_addr [4] = '{8'h10, 8'h11, 8'h12, 8'h13};
        logic [7:0] exp_dat [4]  = '{8'h4A, 8'h4B, 8'h48, 8'h49};
        start = 1'b1; start_addr = 8'h10; start_len = 9'd4; out_ready = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 7; c++) begin
            logic e_rd, e_val, e_last, e_done, e_busy;
            e_rd = (c <= 4); e_val = (c >= 3 && c <= 6); e_last = (c == 6);
            e_done = (c == 7); e_busy = (c <= 6);
            n_total++;
            if (mem_rd_en !== e_rd) $display("FAIL basic_rd_en cyc%0d got %b want %b", c, mem_rd_en, e_rd);
            else n_pass++;
            if (e_rd) begin
                n_total++;
                if (mem_addr !== exp_addr[c-1])
                    $display("FAIL basic_addr cyc%0d got %h want %h", c, mem_addr, exp_addr[c-1]);
                else n_pass++;
            end
            n_total++;
            if (out_valid !== e_val) $display("FAIL basic_valid cyc%0d got %b want %b", c, out_valid, e_val);
            else n_pass++;
            if (e_val) begin
                n_total++;
                if (out_data !== exp_dat[c-3])
                    $display("FAIL basic_data cyc%0d got %h want %h", c, out_data, exp_dat[c-3]);
                else n_pass++;
            end
            n_total++;
            if (out_last !== e_last) $display("FAIL basic_last cyc%0d got %b want %b", c, out_last, e_last);
            else n_pass++;
            n_total++;
            if (done !== e_done) $display("FAIL basic_done cyc%0d got %b want %b", c, done, e_done);
            else n_pass++;
            n_total++;
            if (busy !== e_busy) $display("FAIL basic_busy cyc%0d got %b want %b", c, busy, e_busy);
            else n_pass++;
            tick();
        end
    endtask

    task automatic test_wrap();
        int rb, db;
        bit to;
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        rb = rd_q.size(); db = dat_q.size();
        launch(8'hFE, 9'd4, 100, 40, to);
        n_total++;
        if (to) $display("FAIL wrap_timeout got no done want done within 40 cycles"); else n_pass++;
        n_total++;
        if (rd_q.size() - rb != 4) $display("FAIL wrap_nreads got %0d want 4", rd_q.size() - rb);
        else n_pass++;
        for (int i = 0; i < 4; i++) begin
            logic [7:0] ea, ga, gd;
            logic       gl;
            ea = 8'(8'hFE + i);
            ga = (rb + i < rd_q.size()) ? rd_q[rb+i] : 8'hxx;
            gd = (db + i < dat_q.size()) ? dat_q[db+i] : 8'hxx;
            gl = (db + i < last_q.size()) ? last_q[db+i] : 1'bx;
            n_total++;
            if (ga !== ea) $display("FAIL wrap_addr[%0d] got %h want %h", i, ga, ea); else n_pass++;
            n_total++;
            if (gd !== mem[ea]) $display("FAIL wrap_data[%0d] got %h want %h", i, gd, mem[ea]); else n_pass++;
            n_total++;
            if (gl !== (i == 3)) $display("FAIL wrap_last[%0d] got %b want %b", i, gl, (i == 3)); else n_pass++;
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] a;
        int rb, db, bad, errs;
        bit to;
        a = 8'($urandom);
        tick();
        rb = rd_q.size(); db = dat_q.size();
        out_ready = 1'b0;
        start = 1'b1; start_addr = a; start_len = 9'd10;
        tick();
        start = 1'b0;
        bad = 0;
        for (int c = 1; c <= 20; c++) begin
            if (c >= 3 && !(out_valid === 1'b1 && out_data === mem[a] && out_last === 1'b0)) bad++;
            tick();
        end
        n_total++;
        if (bad != 0) $display("FAIL bp_stall_hold got %0d bad cycles want 0", bad); else n_pass++;
        n_total++;
        if (rd_q.size() - rb != 4) $display("FAIL bp_credit got %0d reads want 4", rd_q.size() - rb);
        else n_pass++;
        n_total++;
        if (dat_q.size() - db != 0) $display("FAIL bp_no_hs got %0d words want 0", dat_q.size() - db);
        else n_pass++;
        out_ready = 1'b1;
        to = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (done === 1'b1) begin
                to = 1'b0;
                break;
            end
            tick();
        end
        n_total++;
        if (to) $display("FAIL bp_timeout got no done want done within 100 cycles"); else n_pass++;
        n_total++;
        if (dat_q.size() - db != 10) $display("FAIL bp_nwords got %0d want 10", dat_q.size() - db);
        else n_pass++;
        errs = 0;
        for (int i = 0; i < 10; i++) begin
            if (db + i >= dat_q.size() || dat_q[db+i] !== mem[8'(a + i)] || last_q[db+i] !== (i == 9)) errs++;
            if (rb + i >= rd_q.size() || rd_q[rb+i] !== 8'(a + i)) errs++;
        end
        n_total++;
        if (errs != 0) $display("FAIL bp_sequence got %0d errors want 0", errs); else n_pass++;
    endtask

    task automatic test_random_ready();
        for (int k = 0; k < 6; k++) begin
            logic [7:0] a;
            int l, rb, db, errs;
            bit to;
            a = 8'($urandom);
            l = int'($urandom_range(40, 1));
            rb = rd_q.size(); db = dat_q.size();
            launch(a, 9'(l), 50, 500, to);
            n_total++;
            if (to) $display("FAIL rand_timeout burst %0d got no done want done", k); else n_pass++;
            n_total++;
            if (dat_q.size() - db != l) $display("FAIL rand_nwords burst %0d got %0d want %0d", k, dat_q.size() - db, l);
            else n_pass++;
            errs = 0;
            for (int i = 0; i < l; i++) begin
                if (db + i >= dat_q.size() || dat_q[db+i] !== mem[8'(a + i)] || last_q[db+i] !== (i == l - 1)) errs++;
                if (rb + i >= rd_q.size() || rd_q[rb+i] !== 8'(a + i)) errs++;
            end
            n_total++;
            if (errs != 0) $display("FAIL rand_sequence burst %0d got %0d errors want 0", k, errs); else n_pass++;
        end
    endtask

    task automatic test_zero_len();
        int bb, vb, rb;
        tick();
        bb = busy_cnt; vb = valid_cnt; rb = rd_q.size();
        start = 1'b1; start_addr = 8'($urandom); start_len = 9'd0;
        tick();
        start = 1'b0;
        n_total++;
        if ({done, busy} !== 2'b10) $display("FAIL zero_done got done,busy=%b want 10", {done, busy}); else n_pass++;
        tick();
        n_total++;
        if (done !== 1'b0) $display("FAIL zero_pulse got %b want 0", done); else n_pass++;
        repeat (3) tick();
        n_total++;
        if (busy_cnt != bb || valid_cnt != vb || rd_q.size() != rb)
            $display("FAIL zero_quiet got busy %0d valid %0d reads %0d want 0 0 0",
                     busy_cnt - bb, valid_cnt - vb, rd_q.size() - rb);
        else n_pass++;
    endtask

    task automatic test_busy_and_reset();
        int rb, db, errs;
        bit to;
        tick();
        rb = rd_q.size();
        out_ready = 1'b1;
        start = 1'b1; start_addr = 8'h40; start_len = 9'd8;
        tick();
        start = 1'b0;
        tick();
        tick();
        start = 1'b1; start_addr = 8'h80; start_len = 9'd3;
        tick();
        start = 1'b0;
        n_total++;
        if (busy !== 1'b1) $display("FAIL br_running got %b want 1", busy); else n_pass++;
        tick();
        reset = 1'b0;
        #1;
        n_total++;
        if ({busy, done, mem_rd_en, out_valid, out_last} !== 5'b0 || out_data !== 8'h00 || mem_addr !== 8'h00)
            $display("FAIL br_async_reset got ctrl %b data %h addr %h want 0",
                     {busy, done, mem_rd_en, out_valid, out_last}, out_data, mem_addr);
        else n_pass++;
        errs = (rd_q.size() - rb != 4) ? 1 : 0;
        for (int i = 0; i < 4; i++)
            if (rb + i >= rd_q.size() || rd_q[rb+i] !== 8'(8'h40 + i)) errs++;
        for (int i = rb; i < rd_q.size(); i++)
            if (rd_q[i] === 8'h80) errs++;
        n_total++;
        if (errs != 0) $display("FAIL br_ignored_start got %0d read errors want 0", errs); else n_pass++;
        tick();
        reset = 1'b1;
        tick();
        n_total++;
        if ({busy, mem_rd_en, out_valid} !== 3'b0)
            $display("FAIL br_post_reset got %b want 000", {busy, mem_rd_en, out_valid});
        else n_pass++;
        rb = rd_q.size(); db = dat_q.size();
        launch(8'h20, 9'd2, 100, 40, to);
        n_total++;
        if (to) $display("FAIL br_timeout got no done want done"); else n_pass++;
        errs = (dat_q.size() - db != 2 || rd_q.size() - rb != 2) ? 1 : 0;
        for (int i = 0; i < 2; i++) begin
            if (db + i >= dat_q.size() || dat_q[db+i] !== mem[8'h20 + i] || last_q[db+i] !== (i == 1)) errs++;
            if (rb + i >= rd_q.size() || rd_q[rb+i] !== 8'(8'h20 + i)) errs++;
        end
        n_total++;
        if (errs != 0) $display("FAIL br_new_burst got %0d errors want 0", errs); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [7:0] a1, a2;
        logic [7:0] exp_q [$];
        int db, errs;
        bit to;
        a1 = 8'($urandom); a2 = 8'($urandom);
        for (int i = 0; i < 2; i++) exp_q.push_back(mem[8'(a1 + i)]);
        for (int i = 0; i < 3; i++) exp_q.push_back(mem[8'(a2 + i)]);
        db = dat_q.size();
        launch(a1, 9'd2, 100, 40, to);
        start = 1'b1; start_addr = a2; start_len = 9'd3;
        tick();
        n_total++;
        if ({busy, mem_rd_en} !== 2'b00) $display("FAIL b2b_done_ignore got %b want 00", {busy, mem_rd_en});
        else n_pass++;
        tick();
        start = 1'b0;
        n_total++;
        if ({busy, mem_rd_en} !== 2'b11 || mem_addr !== a2)
            $display("FAIL b2b_restart got %b addr %h want 11 addr %h", {busy, mem_rd_en}, mem_addr, a2);
        else n_pass++;
        for (int i = 0; i < 40; i++) begin
            if (done === 1'b1) break;
            tick();
        end
        n_total++;
        if (to || done !== 1'b1) $display("FAIL b2b_timeout got done %b want 1", done); else n_pass++;
        errs = (dat_q.size() - db != 5) ? 1 : 0;
        for (int i = 0; i < 5; i++)
            if (db + i >= dat_q.size() || dat_q[db+i] !== exp_q[i] || last_q[db+i] !== (i == 1 || i == 4)) errs++;
        n_total++;
        if (errs != 0) $display("FAIL b2b_sequence got %0d errors want 0", errs); else n_pass++;
    endtask

    task automatic test_full_depth();
        logic [7:0] addrs [2];
        logic [8:0] lens [2] = '{9'd256, 9'h1FF};
        addrs[0] = 8'h37; addrs[1] = 8'($urandom);
        for (int r = 0; r < 2; r++) begin
            int rb, db, errs, span;
            bit to;
            rb = rd_q.size(); db = dat_q.size();
            launch(addrs[r], lens[r], 100, 600, to);
            n_total++;
            if (to) $display("FAIL full_timeout run %0d got no done want done", r); else n_pass++;
            n_total++;
            if (dat_q.size() - db != 256 || rd_q.size() - rb != 256)
                $display("FAIL full_count run %0d got %0d words %0d reads want 256", r, dat_q.size() - db, rd_q.size() - rb);
            else n_pass++;
            errs = 0;
            for (int i = 0; i < 256; i++) begin
                if (db + i >= dat_q.size() || dat_q[db+i] !== mem[8'(addrs[r] + i)] || last_q[db+i] !== (i == 255)) errs++;
                if (rb + i >= rd_q.size() || rd_q[rb+i] !== 8'(addrs[r] + i)) errs++;
            end
            n_total++;
            if (errs != 0) $display("FAIL full_sequence run %0d got %0d errors want 0", r, errs); else n_pass++;
            span = (db + 255 < hs_cyc_q.size()) ? hs_cyc_q[db+255] - hs_cyc_q[db] : -1;
            n_total++;
            if (span != 255) $display("FAIL full_no_bubble run %0d got span %0d want 255", r, span); else n_pass++;
        end
        n_total++;
        if (rd_q.size() < 256 || rd_q[rd_q.size()-1] !== 8'(addrs[1] - 1))
            $display("FAIL full_last_addr got %h want %h", rd_q[rd_q.size()-1], 8'(addrs[1] - 1));
        else n_pass++;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
        test_reset();
        test_basic();
        test_wrap();
        test_backpressure();
        test_random_ready();
        test_zero_len();
        test_busy_and_reset();
        test_back_to_back();
        test_full_depth();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
